// File: rtl/async_fifo_wptr_ctl.sv
// async_fifo_wptr_ctl
// Write-domain pointer and flag controller for an asynchronous FIFO.
// Produces the binary RAM write address and the Gray write pointer for CDC.
// Also produces registered full, almost-full and fill-level flags. These are
// derived from the read pointer after it has been synchronised into wclk_i.
//
// Optional feature macro: WPTR_OVERFLOW_EN
//   When defined, a sticky overflow flag and a saturating rejected-write
//   counter are built. When undefined, both outputs are tied to 0 and
//   ovf_clr_i is ignored.
//
// Ports:
//   wclk_i           write clock
//   wrst_n_i         asynchronous active-low reset
//   wen              write request
//   rptr_sync2_wrclk Gray read pointer, synchronised into wclk_i
//   af_thresh_i      almost-full level threshold (0 disables the level term)
//   ovf_clr_i        clears overflow status
//   wr_ack           combinational RAM write enable (wen & ~fifo_full)
//   wr_addr          binary RAM write address
//   wptr_g           registered Gray write pointer to the read domain
//   fifo_full        registered full flag
//   fifo_almost_full registered almost-full flag
//   wr_level         registered write-side fill level, 0..2**ADDRSIZE
//   overflow         sticky flag for writes attempted while full
//   ovf_count        saturating count of rejected writes
module async_fifo_wptr_ctl #(
  parameter int unsigned ADDRSIZE  = 4,
  parameter int unsigned OVF_CNT_W = 8
) (
  input  logic                 wclk_i,
  input  logic                 wrst_n_i,
  input  logic                 wen,
  input  logic [ADDRSIZE:0]    rptr_sync2_wrclk,
  input  logic [ADDRSIZE:0]    af_thresh_i,
  input  logic                 ovf_clr_i,
  output logic                 wr_ack,
  output logic [ADDRSIZE-1:0]  wr_addr,
  output logic [ADDRSIZE:0]    wptr_g,
  output logic                 fifo_full,
  output logic                 fifo_almost_full,
  output logic [ADDRSIZE:0]    wr_level,
  output logic                 overflow,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  localparam int unsigned PW = ADDRSIZE + 1;

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_wptr_g;
  logic [PW-1:0] r_level;
  logic          r_full;
  logic          r_afull;

  logic          w_wr_ack;
  logic          w_ovf_evt;
  logic [PW-1:0] w_wbin_next;
  logic [PW-1:0] w_wgray_next;
  logic [PW-1:0] w_rbin_sync;
  logic [PW-1:0] w_level_next;
  logic [PW-1:0] w_full_cmp;
  logic          w_full_next;
  logic          w_afull_next;

  // Writes are accepted only while not full; a write attempted while full is an overflow event.
  assign w_wr_ack  = wen & ~r_full;
  assign w_ovf_evt = wen & r_full;

  assign w_wbin_next  = r_wbin + PW'(w_wr_ack);
  assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

  // Gray to binary: each bit is the XOR of itself and every higher Gray bit.
  always_comb begin
    w_rbin_sync = '0;
    for (int i = 0; i < int'(PW); i++) begin
      w_rbin_sync[i] = ^(rptr_sync2_wrclk >> i);
    end
  end

  assign w_level_next = w_wbin_next - w_rbin_sync;

  // In Gray code, full means the top two bits are inverted and the rest match.
  assign w_full_cmp   = {~rptr_sync2_wrclk[PW-1:PW-2], rptr_sync2_wrclk[PW-3:0]};
  assign w_full_next  = (w_wgray_next == w_full_cmp);
  assign w_afull_next = w_full_next |
                        ((af_thresh_i != '0) && (w_level_next >= af_thresh_i));

  // Pointer and flag registers. The flags are computed from next-state
  // values, so they update on the same edge as the write.
  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      r_wbin   <= '0;
      r_wptr_g <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      r_wbin   <= w_wbin_next;
      r_wptr_g <= w_wgray_next;
      r_level  <= w_level_next;
      r_full   <= w_full_next;
      r_afull  <= w_afull_next;
    end
  end

  assign wr_ack           = w_wr_ack;
  assign wr_addr          = r_wbin[ADDRSIZE-1:0];
  assign wptr_g           = r_wptr_g;
  assign fifo_full        = r_full;
  assign fifo_almost_full = r_afull;
  assign wr_level         = r_level;

`ifdef WPTR_OVERFLOW_EN
  logic                 r_overflow;
  logic [OVF_CNT_W-1:0] r_ovf_count;

  // Sticky overflow status. A new event takes priority over a clear in
  // the same cycle.
  always_ff @(posedge wclk_i or negedge wrst_n_i) begin
    if (!wrst_n_i) begin
      r_overflow  <= 1'b0;
      r_ovf_count <= '0;
    end else begin
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr_i) begin
        r_overflow <= 1'b0;
      end
      if (ovf_clr_i) begin
        r_ovf_count <= OVF_CNT_W'(w_ovf_evt);
      end else if (w_ovf_evt && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + OVF_CNT_W'(1);
      end
    end
  end

  assign overflow  = r_overflow;
  assign ovf_count = r_ovf_count;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ovf_clr_i | w_ovf_evt;
  assign overflow     = 1'b0;
  assign ovf_count    = '0;
`endif

endmodule

// File: tb/tb_async_fifo_wptr_ctl.sv
// Testbench for async_fifo_wptr_ctl (ADDRSIZE=3, depth 8).
// Stimulus pushes hand-computed expectations into a queue.
// A monitor samples wr_ack/wr_addr shortly before each rising edge and the
// registered outputs shortly after it, then pops the queue and compares.
module tb_async_fifo_wptr_ctl;

  localparam int unsigned AW = 3;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 8;
`ifdef WPTR_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          wclk_i = 1'b0;
  logic          wrst_n_i;
  logic          wen;
  logic [PW-1:0] rptr_sync2_wrclk;
  logic [PW-1:0] af_thresh_i;
  logic          ovf_clr_i;
  logic          wr_ack;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wptr_g;
  logic          fifo_full;
  logic          fifo_almost_full;
  logic [PW-1:0] wr_level;
  logic          overflow;
  logic [CW-1:0] ovf_count;

  async_fifo_wptr_ctl #(.ADDRSIZE(AW), .OVF_CNT_W(CW)) dut (
    .wclk_i           (wclk_i),
    .wrst_n_i         (wrst_n_i),
    .wen              (wen),
    .rptr_sync2_wrclk (rptr_sync2_wrclk),
    .af_thresh_i      (af_thresh_i),
    .ovf_clr_i        (ovf_clr_i),
    .wr_ack           (wr_ack),
    .wr_addr          (wr_addr),
    .wptr_g           (wptr_g),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .wr_level         (wr_level),
    .overflow         (overflow),
    .ovf_count        (ovf_count)
  );

  always #5 wclk_i = ~wclk_i;

  // Expected values; -1 means the field is not checked.
  typedef struct {
    int ack; int addr; int wptr; int full; int af; int lvl; int ovf; int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Hand table of 4-bit binary-to-Gray values.
  int g[16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  task automatic cmp(input string name, input int act, input int exp);
    if (exp >= 0) begin
      n_vec++;
      if (act != exp) begin
        n_err++;
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Apply one cycle of inputs at the falling edge and queue its expectation.
  task automatic cyc(input logic w, input logic [PW-1:0] rp, input logic [PW-1:0] th,
                     input logic clr, input int ack, input int addr, input int wp,
                     input int full, input int af, input int lvl, input int ovf,
                     input int cnt);
    exp_t e;
    @(negedge wclk_i);
    wen              = w;
    rptr_sync2_wrclk = rp;
    af_thresh_i      = th;
    ovf_clr_i        = clr;
    e = '{ack, addr, wp, full, af, lvl, ovf, cnt};
    sb_q.push_back(e);
  endtask

  // Monitor: pre-edge sample of combinational outputs, post-edge sample of registers.
  initial begin
    int   s_ack;
    int   s_addr;
    exp_t e;
    forever begin
      @(negedge wclk_i);
      #3;
      s_ack  = int'(wr_ack);
      s_addr = int'(wr_addr);
      @(posedge wclk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp("wr_ack",   s_ack,                   e.ack);
        cmp("wr_addr",  s_addr,                  e.addr);
        cmp("wptr_g",   int'(wptr_g),            e.wptr);
        cmp("full",     int'(fifo_full),         e.full);
        cmp("afull",    int'(fifo_almost_full),  e.af);
        cmp("level",    int'(wr_level),          e.lvl);
        cmp("overflow", int'(overflow),          e.ovf);
        cmp("ovf_cnt",  int'(ovf_count),         e.cnt);
      end
    end
  end

  initial begin
    int wait_cnt;
    wrst_n_i         = 1'b0;
    wen              = 1'b0;
    rptr_sync2_wrclk = '0;
    af_thresh_i      = PW'(6);
    ovf_clr_i        = 1'b0;
    #2;
    cmp("rst_wptr",  int'(wptr_g),           0);
    cmp("rst_full",  int'(fifo_full),        0);
    cmp("rst_level", int'(wr_level),         0);
    cmp("rst_addr",  int'(wr_addr),          0);
    repeat (2) @(negedge wclk_i);
    wrst_n_i = 1'b1;

    // Idle cycle after reset.
    cyc(1'b0, 4'd0, 4'd6, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Fill to full with threshold 6.
    for (int k = 1; k <= 8; k++)
      cyc(1'b1, 4'd0, 4'd6, 1'b0, 1, k - 1, g[k], int'(k == 8), int'(k >= 6), k, 0, 0);

    // Rejected writes while full.
    for (int k = 1; k <= 3; k++)
      cyc(1'b1, 4'd0, 4'd6, 1'b0, 0, 0, 12, 1, 1, 8, OVF_EN ? 1 : 0, OVF_EN ? k : 0);
    // A clear in the same cycle as a rejected write: the set wins and the count loads 1.
    cyc(1'b1, 4'd0, 4'd6, 1'b1, 0, 0, 12, 1, 1, 8, OVF_EN ? 1 : 0, OVF_EN ? 1 : 0);
    // A clear on its own.
    cyc(1'b0, 4'd0, 4'd6, 1'b1, 0, 0, 12, 1, 1, 8, 0, 0);

    // Read pointer reaches binary 8; use threshold 0 so only full drives almost-full.
    cyc(1'b0, 4'b1100, 4'd0, 1'b0, 0, 0, 12, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      cyc(1'b1, 4'b1100, 4'd0, 1'b0, 1, k - 1, g[(8 + k) % 16], int'(k == 8),
          int'(k == 8), k, 0, 0);

    // Read pointer reaches binary 12 (level 4), then write and advance the read pointer together.
    cyc(1'b0, 4'b1010, 4'd0, 1'b0, 0, 0, 0, 0, 0, 4, 0, 0);
    cyc(1'b1, 4'b1011, 4'd0, 1'b0, 1, 0, 1, 0, 0, 4, 0, 0);

    // Grow to level 7 with threshold 6.
    for (int k = 1; k <= 3; k++)
      cyc(1'b1, 4'b1011, 4'd6, 1'b0, 1, k, g[1 + k], 0, int'(4 + k >= 6), 4 + k, 0, 0);
    // Threshold above the depth: almost-full follows full only.
    cyc(1'b0, 4'b1011, 4'd9, 1'b0, 0, 4, 6, 0, 0, 7, 0, 0);

    // Asynchronous reset mid-operation with wen high.
    @(negedge wclk_i);
    wen = 1'b1;
    #2;
    wrst_n_i = 1'b0;
    #1;
    cmp("mid_rst_wptr",  int'(wptr_g),           0);
    cmp("mid_rst_full",  int'(fifo_full),        0);
    cmp("mid_rst_afull", int'(fifo_almost_full), 0);
    cmp("mid_rst_level", int'(wr_level),         0);
    cmp("mid_rst_addr",  int'(wr_addr),          0);
    cmp("mid_rst_ack",   int'(wr_ack),           1);
    cmp("mid_rst_ovf",   int'(overflow),         0);
    cmp("mid_rst_cnt",   int'(ovf_count),        0);
    @(negedge wclk_i);
    wen      = 1'b0;
    wrst_n_i = 1'b1;
    cyc(1'b1, 4'd0, 4'd6, 1'b0, 1, 0, 1, 0, 0, 1, 0, 0);
    cyc(1'b0, 4'd0, 4'd6, 1'b0, 0, 1, 1, 0, 0, 1, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(negedge wclk_i);
      wait_cnt++;
    end
    if (sb_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
